// File: rtl/reg_file_dbg_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// reg_dbg_pkg
// Shared definitions for the register-file debug controller: command opcode
// encodings, controller state encoding and default widths.
// No ports (package).
// ---------------------------------------------------------------------------
package reg_dbg_pkg;

  localparam int DATA_W_DEF  = 8;
  localparam int ADDR_W_DEF  = 4;
  localparam int HALT_TO_DEF = 255;

  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_WRITE = 2'b01,
    OP_DUMP  = 2'b10,
    OP_CLEAR = 2'b11
  } dbg_op_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_EXEC = 3'd2,
    ST_RESP = 3'd3,
    ST_REL  = 3'd4
  } dbg_state_e;

endpackage

// File: rtl/reg_file_dbg_ctrl_if.sv
// ---------------------------------------------------------------------------
// reg_file_dbg_ctrl_if
// Command / response channels between the debug bridge (master) and the
// register-file debug controller (slave).
//   cmd_valid/cmd_ready  command handshake
//   cmd_op/addr/data     command payload (op: 00 READ 01 WRITE 10 DUMP 11 CLEAR)
//   rsp_valid/rsp_ready  response handshake
//   rsp_addr/data        register the response refers to and its data
//   rsp_last/rsp_err     final response of a command / timeout or protection
// ---------------------------------------------------------------------------
interface reg_file_dbg_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) ();

  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_data;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [ADDR_W-1:0] rsp_addr;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_last;
  logic              rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_addr, rsp_data, rsp_last, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_addr, rsp_data, rsp_last, rsp_err
  );

endinterface

// File: rtl/reg_file_dbg_ctrl_halt.sv
// ---------------------------------------------------------------------------
// dbg_halt_handshake
// Owns the CPU halt request and the halt-acknowledge timeout.
//   clk, rst_n  clock / asynchronous active-low reset
//   start       pulse: raise dbg_req and start waiting for dbg_ack
//   drop        pulse: lower dbg_req (controller finished with the regfile)
//   dbg_ack     CPU halted
//   dbg_req     registered halt request
//   granted     pulse while waiting and dbg_ack is seen
//   timeout     pulse on the HALT_TO-th waiting cycle without dbg_ack
//   released    dbg_req low and dbg_ack low (halt fully released)
// ---------------------------------------------------------------------------
module dbg_halt_handshake #(
  parameter int HALT_TO = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic drop,
  input  logic dbg_ack,
  output logic dbg_req,
  output logic granted,
  output logic timeout,
  output logic released
);

  localparam int CNT_W = (HALT_TO < 2) ? 1 : $clog2(HALT_TO + 1);

  logic             dbg_req_reg;
  logic             waiting_reg;
  logic [CNT_W-1:0] cnt_reg;

  // cnt_reg counts completed waiting cycles, so the HALT_TO-th waiting cycle
  // is the one where it still reads HALT_TO-1. An ack in that same cycle wins.
  assign granted  = waiting_reg & dbg_ack;
  assign timeout  = waiting_reg & ~dbg_ack & (cnt_reg == CNT_W'(HALT_TO - 1));
  assign released = ~dbg_req_reg & ~dbg_ack;
  assign dbg_req  = dbg_req_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dbg_req_reg <= 1'b0;
      waiting_reg <= 1'b0;
      cnt_reg     <= '0;
    end else if (start) begin
      dbg_req_reg <= 1'b1;
      waiting_reg <= 1'b1;
      cnt_reg     <= '0;
    end else begin
      if (drop) dbg_req_reg <= 1'b0;
      if (granted || timeout) waiting_reg <= 1'b0;
      else if (waiting_reg)   cnt_reg     <= cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/reg_file_dbg_ctrl.sv
// ---------------------------------------------------------------------------
// reg_file_dbg_ctrl
// Debug access controller driving the CPU register file while the CPU is
// halted. Commands READ / WRITE / DUMP / CLEAR arrive on the slave side of
// reg_file_dbg_ctrl_if; results leave on its response channel.
// Ports:
//   clk, rst_n  clock / asynchronous active-low reset
//   dbg_if      command/response channels (slave modport)
//   dbg_req     halt request to CPU control; dbg_ack CPU halted
//   wp_mask     per-register write protect (only with DBG_WRITE_PROTECT_EN)
//   rf_addr/rf_we/rf_wr_data  register file write / X-read port
//   rf_rd_data  asynchronous X read data
// Build option: define DBG_WRITE_PROTECT_EN to honour wp_mask on WRITE/CLEAR.
// ---------------------------------------------------------------------------
module reg_file_dbg_ctrl
  import reg_dbg_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int HALT_TO = HALT_TO_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  reg_file_dbg_ctrl_if.slave   dbg_if,
  output logic                 dbg_req,
  input  logic                 dbg_ack,
  input  logic [2**ADDR_W-1:0] wp_mask,
  output logic [ADDR_W-1:0]    rf_addr,
  output logic                 rf_we,
  output logic [DATA_W-1:0]    rf_wr_data,
  input  logic [DATA_W-1:0]    rf_rd_data
);

  localparam logic [ADDR_W-1:0] LAST_IDX = '1;

  dbg_state_e        state_reg;
  dbg_op_e           op_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] data_reg;
  logic [ADDR_W-1:0] idx_reg;
  logic              cmd_ready_reg;
  logic              rsp_valid_reg;
  logic [ADDR_W-1:0] rsp_addr_reg;
  logic [DATA_W-1:0] rsp_data_reg;
  logic              rsp_last_reg;
  logic              rsp_err_reg;
  logic [ADDR_W-1:0] rf_addr_reg;
  logic              rf_we_reg;
  logic [DATA_W-1:0] rf_wr_data_reg;
  logic              clr_skip_reg;   // a CLEAR skipped at least one protected register

  logic              start, drop, more_dump;
  logic              granted, timeout, released;
  logic [ADDR_W-1:0] idx_inc;
  logic              prot_addr, prot_first, prot_next;

  assign idx_inc   = idx_reg + 1'b1;
  assign start     = (state_reg == ST_IDLE) && dbg_if.cmd_valid;
  assign more_dump = (op_reg == OP_DUMP) && (idx_reg != LAST_IDX);
  assign drop      = (state_reg == ST_RESP) && dbg_if.rsp_ready && !more_dump;

`ifdef DBG_WRITE_PROTECT_EN
  assign prot_addr  = wp_mask[addr_reg];
  assign prot_first = wp_mask[0];
  assign prot_next  = wp_mask[idx_inc];
`else
  assign prot_addr  = 1'b0;
  assign prot_first = 1'b0;
  assign prot_next  = 1'b0;
  logic unused_wp;
  assign unused_wp = ^wp_mask;
`endif

  dbg_halt_handshake #(.HALT_TO(HALT_TO)) u_halt (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .drop     (drop),
    .dbg_ack  (dbg_ack),
    .dbg_req  (dbg_req),
    .granted  (granted),
    .timeout  (timeout),
    .released (released)
  );

  // rf_* are registered: they are loaded on the edge that enters an EXEC
  // cycle, so the regfile sees them for exactly that cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      op_reg         <= OP_READ;
      addr_reg       <= '0;
      data_reg       <= '0;
      idx_reg        <= '0;
      cmd_ready_reg  <= 1'b1;
      rsp_valid_reg  <= 1'b0;
      rsp_addr_reg   <= '0;
      rsp_data_reg   <= '0;
      rsp_last_reg   <= 1'b0;
      rsp_err_reg    <= 1'b0;
      rf_addr_reg    <= '0;
      rf_we_reg      <= 1'b0;
      rf_wr_data_reg <= '0;
      clr_skip_reg   <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (dbg_if.cmd_valid) begin
            op_reg        <= dbg_op_e'(dbg_if.cmd_op);
            addr_reg      <= dbg_if.cmd_addr;
            data_reg      <= dbg_if.cmd_data;
            idx_reg       <= '0;
            cmd_ready_reg <= 1'b0;
            state_reg     <= ST_REQ;
          end
        end

        ST_REQ: begin
          if (granted) begin
            state_reg <= ST_EXEC;
            case (op_reg)
              OP_READ:  rf_addr_reg <= addr_reg;
              OP_WRITE: begin
                rf_addr_reg    <= addr_reg;
                rf_we_reg      <= ~prot_addr;
                rf_wr_data_reg <= data_reg;
              end
              OP_DUMP:  rf_addr_reg <= idx_reg;
              OP_CLEAR: begin
                rf_addr_reg    <= '0;
                rf_we_reg      <= ~prot_first;
                rf_wr_data_reg <= '0;
                clr_skip_reg   <= prot_first;
              end
            endcase
          end else if (timeout) begin
            state_reg     <= ST_RESP;
            rsp_valid_reg <= 1'b1;
            rsp_addr_reg  <= addr_reg;
            rsp_data_reg  <= '0;
            rsp_last_reg  <= 1'b1;
            rsp_err_reg   <= 1'b1;
          end
        end

        ST_EXEC: begin
          rf_we_reg      <= 1'b0;
          rf_addr_reg    <= '0;
          rf_wr_data_reg <= '0;
          case (op_reg)
            OP_READ: begin
              rsp_data_reg <= rf_rd_data;
              rsp_addr_reg <= addr_reg;
              rsp_last_reg <= 1'b1;
              rsp_err_reg  <= 1'b0;
            end
            OP_WRITE: begin
              rsp_data_reg <= data_reg;
              rsp_addr_reg <= addr_reg;
              rsp_last_reg <= 1'b1;
              rsp_err_reg  <= prot_addr;
            end
            OP_DUMP: begin
              rsp_data_reg <= rf_rd_data;
              rsp_addr_reg <= idx_reg;
              rsp_last_reg <= (idx_reg == LAST_IDX);
              rsp_err_reg  <= 1'b0;
            end
            OP_CLEAR: begin
              rsp_data_reg <= '0;
              rsp_addr_reg <= LAST_IDX;
              rsp_last_reg <= 1'b1;
              rsp_err_reg  <= clr_skip_reg;
            end
          endcase
          // CLEAR stays in EXEC, one register per cycle, until the last index
          if (op_reg == OP_CLEAR && idx_reg != LAST_IDX) begin
            idx_reg        <= idx_inc;
            rf_addr_reg    <= idx_inc;
            rf_we_reg      <= ~prot_next;
            clr_skip_reg   <= clr_skip_reg | prot_next;
          end else begin
            rsp_valid_reg <= 1'b1;
            state_reg     <= ST_RESP;
          end
        end

        ST_RESP: begin
          if (dbg_if.rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            if (more_dump) begin
              idx_reg     <= idx_inc;
              rf_addr_reg <= idx_inc;
              state_reg   <= ST_EXEC;
            end else begin
              state_reg <= ST_REL;
            end
          end
        end

        ST_REL: begin
          if (released) begin
            cmd_ready_reg <= 1'b1;
            state_reg     <= ST_IDLE;
          end
        end

        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign dbg_if.cmd_ready = cmd_ready_reg;
  assign dbg_if.rsp_valid = rsp_valid_reg;
  assign dbg_if.rsp_addr  = rsp_addr_reg;
  assign dbg_if.rsp_data  = rsp_data_reg;
  assign dbg_if.rsp_last  = rsp_last_reg;
  assign dbg_if.rsp_err   = rsp_err_reg;
  assign rf_addr          = rf_addr_reg;
  assign rf_we            = rf_we_reg;
  assign rf_wr_data       = rf_wr_data_reg;

endmodule

// File: tb/tb_reg_file_dbg_ctrl.sv
// ---------------------------------------------------------------------------
// tb_reg_file_dbg_ctrl
// Scoreboard bench for reg_file_dbg_ctrl: directed commands push expected
// responses; a negedge monitor pops and compares on every response handshake.
// A small behavioural register file sits on the rf_* port.
// ---------------------------------------------------------------------------
module tb_reg_file_dbg_ctrl;
  import reg_dbg_pkg::*;

  localparam int DW   = 8;
  localparam int AW   = 4;
  localparam int HT   = 20;
  localparam int NREG = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  reg_file_dbg_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  logic            dbg_req, dbg_ack;
  logic            ack_tie = 1'b1;
  logic [NREG-1:0] wp_mask = '0;
  logic [AW-1:0]   rf_addr;
  logic            rf_we;
  logic [DW-1:0]   rf_wr_data, rf_rd_data;

  assign dbg_ack = ack_tie & dbg_req;

  reg_file_dbg_ctrl #(.DATA_W(DW), .ADDR_W(AW), .HALT_TO(HT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .dbg_if     (bus),
    .dbg_req    (dbg_req),
    .dbg_ack    (dbg_ack),
    .wp_mask    (wp_mask),
    .rf_addr    (rf_addr),
    .rf_we      (rf_we),
    .rf_wr_data (rf_wr_data),
    .rf_rd_data (rf_rd_data)
  );

  // behavioural register file, optional preload to 0x10+i
  logic [DW-1:0] rf_mem [NREG];
  logic          preload_en = 1'b0;
  always @(posedge clk) begin
    if (preload_en) begin
      for (int i = 0; i < NREG; i++) rf_mem[i] <= DW'(16 + i);
    end else if (rf_we) begin
      rf_mem[rf_addr] <= rf_wr_data;
    end
  end
  assign rf_rd_data = rf_mem[rf_addr];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          last;
    logic          err;
    bit            chk_addr;
  } rsp_t;
  rsp_t exp_q[$];

  task automatic push(input int a, input int d, input bit l, input bit e, input bit ca);
    rsp_t r;
    r.addr = AW'(a); r.data = DW'(d); r.last = l; r.err = e; r.chk_addr = ca;
    exp_q.push_back(r);
  endtask

  logic        stalled = 1'b0;
  logic [14:0] held;
  logic [14:0] cur;
  always @(negedge clk) begin
    if (rst_n) begin
      cur = {bus.rsp_valid, bus.rsp_err, bus.rsp_last, bus.rsp_addr, bus.rsp_data};
      if (stalled) chk("rsp_hold", 32'(cur), 32'(held));
      if (bus.rsp_valid && bus.rsp_ready) begin
        $display("rsp addr=%0d data=0x%02h last=%0b err=%0b", bus.rsp_addr, bus.rsp_data,
                 bus.rsp_last, bus.rsp_err);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rsp_unexpected: got addr=%0d data=0x%0h, required no response",
                   bus.rsp_addr, bus.rsp_data);
        end else begin
          rsp_t e;
          e = exp_q.pop_front();
          if (e.chk_addr) chk("rsp_addr", 32'(bus.rsp_addr), 32'(e.addr));
          chk("rsp_data", 32'(bus.rsp_data), 32'(e.data));
          chk("rsp_last", 32'(bus.rsp_last), 32'(e.last));
          chk("rsp_err", 32'(bus.rsp_err), 32'(e.err));
        end
      end
      stalled = bus.rsp_valid && !bus.rsp_ready;
      held    = cur;
    end else begin
      stalled = 1'b0;
    end
  end

  // register-file write log
  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int            c;
  } wr_t;
  wr_t wr_q[$];
  always @(negedge clk) begin
    if (rst_n && rf_we) begin
      wr_t w;
      w.a = rf_addr; w.d = rf_wr_data; w.c = cyc;
      wr_q.push_back(w);
    end
  end

  // response-ready driver: 0 = always ready, 1 = toggle every cycle
  int ready_mode = 0;
  initial begin
    bus.rsp_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 1) bus.rsp_ready = ~bus.rsp_ready;
      else                 bus.rsp_ready = 1'b1;
    end
  end

  // returns 1 time unit after the accepting edge
  task automatic send(input logic [1:0] op, input int a, input int d);
    int n = 0;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_addr  = AW'(a);
    bus.cmd_data  = DW'(d);
    @(negedge clk);
    while (!bus.cmd_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!bus.cmd_ready) begin
      checks++;
      errors++;
      $display("FAIL cmd_accept: cmd_ready=0 after %0d cycles, required 1", n);
    end
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    $display("cmd op=%0d addr=%0d data=0x%02h", op, a, d);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(exp_q.size() == 0 && bus.cmd_ready) && n < 2000);
    chk(name, 32'(exp_q.size() == 0 && bus.cmd_ready), 32'd1);
  endtask

  task automatic preload();
    @(posedge clk);
    #1 preload_en = 1'b1;
    @(posedge clk);
    #1 preload_en = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit found;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
    bus.cmd_addr  = '0;
    bus.cmd_data  = '0;
    preload_en    = 1'b1;
    repeat (2) @(posedge clk);
    #1 preload_en = 1'b0;

    // reset state
    @(negedge clk);
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_dbg_req", 32'(dbg_req), 32'd0);
    chk("rst_rf_we", 32'(rf_we), 32'd0);
    chk("rst_rf_addr", 32'(rf_addr), 32'd0);
    chk("rst_rsp_fields", 32'({bus.rsp_last, bus.rsp_err, bus.rsp_addr, bus.rsp_data}), 32'd0);
    rst_n = 1'b1;

    // WRITE 5 <- 0xA7
    wr_q.delete();
    push(5, 'hA7, 1, 0, 1);
    send(OP_WRITE, 5, 'hA7);
    wait_done("write5_done");
    chk("write5_we_count", 32'(wr_q.size()), 32'd1);
    if (wr_q.size() == 1) begin
      chk("write5_rf_addr", 32'(wr_q[0].a), 32'd5);
      chk("write5_rf_data", 32'(wr_q[0].d), 32'hA7);
    end

    // READ 5 with cycle-exact latency
    push(5, 'hA7, 1, 0, 1);
    send(OP_READ, 5, 0);
    @(negedge clk);
    chk("rd_c1_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rd_c1_req", 32'(dbg_req), 32'd1);
    @(negedge clk);
    chk("rd_c2_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rd_c2_rf_addr", 32'(rf_addr), 32'd5);
    @(negedge clk);
    chk("rd_c3_valid", 32'(bus.rsp_valid), 32'd1);
    wait_done("read5_done");

    // DUMP of preloaded file with a stalling consumer
    preload();
    for (int i = 0; i < NREG; i++) push(i, 16 + i, i == NREG - 1, 0, 1);
    ready_mode = 1;
    send(OP_DUMP, 0, 0);
    wait_done("dump_done");
    ready_mode = 0;

    // CLEAR: 16 back-to-back writes of zero
    wr_q.delete();
    push(15, 0, 1, 0, 1);
    send(OP_CLEAR, 0, 0);
    wait_done("clear_done");
    chk("clear_we_count", 32'(wr_q.size()), 32'd16);
    for (int i = 0; i < wr_q.size() && i < NREG; i++) begin
      chk("clear_rf_addr", 32'(wr_q[i].a), 32'(i));
      chk("clear_rf_data", 32'(wr_q[i].d), 32'd0);
      if (i > 0) chk("clear_consecutive", 32'(wr_q[i].c - wr_q[i-1].c), 32'd1);
    end
    for (int i = 0; i < NREG; i++) push(i, 0, i == NREG - 1, 0, 1);
    send(OP_DUMP, 0, 0);
    wait_done("dump_zero_done");

    // halt timeout
    ack_tie = 1'b0;
    push(2, 0, 1, 1, 0);
    send(OP_READ, 2, 0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.rsp_valid && n < HT + 50);
    chk("timeout_cycle", 32'(n), 32'(HT + 1));
    chk("timeout_req_in_resp", 32'(dbg_req), 32'd1);
    @(negedge clk);
    chk("timeout_req_rel", 32'(dbg_req), 32'd0);
    chk("timeout_ready_rel", 32'(bus.cmd_ready), 32'd0);
    @(negedge clk);
    chk("timeout_ready_back", 32'(bus.cmd_ready), 32'd1);
    wait_done("timeout_done");
    ack_tie = 1'b1;

    // reset in the middle of a DUMP at index 7
    preload();
    for (int i = 0; i < 8; i++) push(i, 16 + i, 0, 0, 1);
    send(OP_DUMP, 0, 0);
    found = 1'b0;
    n = 0;
    while (!found && n < 200) begin
      @(negedge clk);
      n++;
      found = bus.rsp_valid && (bus.rsp_addr == AW'(7));
    end
    chk("midrst_reach_idx7", 32'(found), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_dbg_req", 32'(dbg_req), 32'd0);
    chk("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("midrst_rf_we", 32'(rf_we), 32'd0);
    chk("midrst_rf_addr", 32'(rf_addr), 32'd0);
    chk("midrst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("postrst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    push(9, 'h19, 1, 0, 1);
    send(OP_READ, 9, 0);
    wait_done("postrst_read_done");

`ifdef DBG_WRITE_PROTECT_EN
    wp_mask = 16'h0008;
    wr_q.delete();
    push(3, 'h55, 1, 1, 1);
    send(OP_WRITE, 3, 'h55);
    wait_done("wp_write_done");
    chk("wp_we_count", 32'(wr_q.size()), 32'd0);
    push(3, 'h13, 1, 0, 1);
    send(OP_READ, 3, 0);
    wait_done("wp_read_done");
    wp_mask = '0;
`endif

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
